// File: rtl/pwr_kill_sequencer_pkg.sv
// Shared definitions for the kill-switch / rail sequencer:
// FSM codes, register map and bit positions.
package pwr_kill_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_ARMING = 3'd1,
    ST_RAMP   = 3'd2,
    ST_ON     = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_KCOUNT = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_CLEAR  = 1;

  localparam int STAT_KILL  = 3;
  localparam int STAT_FAULT = 4;
  localparam int STAT_MOTOR = 8;

  localparam logic [15:0] KCOUNT_MAX = 16'hFFFF;

  // Down-counters terminate at zero, so a span of p cycles loads p-1.
  function automatic int unsigned cnt_load(int unsigned p);
    return (p == 0) ? 0 : p - 1;
  endfunction

endpackage

// File: rtl/pwr_kill_sequencer_debounce.sv
// Two-flop synchronizer followed by a stable-run counter;
// the output follows the input only after CYCLES steady samples.
module pwr_kill_sequencer_debounce #(
  parameter int unsigned CYCLES = 50000,
  parameter logic        INIT   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int CW = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'((CYCLES == 0) ? 0 : CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          flip;

  assign flip = (s2 != dout) && (cnt >= LAST);
  assign rise = flip && s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1   <= INIT;
      s2   <= INIT;
      cnt  <= '0;
      dout <= INIT;
    end else begin
      s1 <= din;
      s2 <= s1;
      if ((s2 == dout) || flip) cnt <= '0;
      else                      cnt <= cnt + 1'b1;
      if (flip) dout <= s2;
    end
  end

endmodule

// File: rtl/pwr_kill_sequencer.sv
// Kill-switch debounce, fault latch and staggered motor rail
// sequencer with an Avalon-MM control/status slave.
module pwr_kill_sequencer
  import pwr_kill_sequencer_pkg::*;
#(
  parameter int unsigned N_RAILS         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned ARM_DELAY       = 25000000,
  parameter int unsigned STAGGER         = 2500000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               chipselect,
  input  logic [1:0]         address,
  input  logic               write,
  input  logic               read,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  input  logic               kill_sw,
  input  logic               error,
  output logic [N_RAILS-1:0] motor_en,
  output logic               fault
);

  localparam int AW = $clog2(ARM_DELAY + 1);
  localparam int SW = $clog2(STAGGER + 1);
  localparam int CW = (AW > SW) ? ((AW > 0) ? AW : 1)
                                : ((SW > 0) ? SW : 1);

  localparam logic [CW-1:0] ARM_LOAD = CW'(cnt_load(ARM_DELAY));
  localparam logic [CW-1:0] STG_LOAD = CW'(cnt_load(STAGGER));
  localparam logic [2:0]    LAST_IDX = 3'(N_RAILS - 1);
  localparam logic [N_RAILS-1:0] ALL_ON = '1;

  logic               kill_db;
  logic               kill_rise;
  logic               err_m;
  logic               err_s;
  logic               enable;
  logic [15:0]        kill_count;
  state_t             state;
  state_t             nxt_state;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      nxt_cnt;
  logic [2:0]         idx;
  logic [2:0]         nxt_idx;
  logic [N_RAILS-1:0] nxt_en;
  logic [31:0]        rd_mux;
  logic               wr;
  logic               rd;
  logic               clr;
  logic               unused_wd;

  assign unused_wd = ^writedata[31:2];

  pwr_kill_sequencer_debounce #(
    .CYCLES (DEBOUNCE_CYCLES),
    .INIT   (1'b1)
  ) u_kill_db (
    .clk   (clk),
    .reset (reset),
    .din   (kill_sw),
    .dout  (kill_db),
    .rise  (kill_rise)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_m <= 1'b0;
      err_s <= 1'b0;
    end else begin
      err_m <= error;
      err_s <= err_m;
    end
  end

  assign wr  = chipselect && write;
  assign rd  = chipselect && read && !wr;
  assign clr = wr && (address == REG_CTRL) && writedata[CTRL_CLEAR];

  // Fault outranks kill/disable; once latched only a clear leaves it.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_idx   = idx;
    nxt_en    = motor_en;
    if (err_s) begin
      nxt_state = ST_FAULT;
      nxt_cnt   = '0;
      nxt_idx   = '0;
      nxt_en    = '0;
    end else if (state == ST_FAULT) begin
      nxt_en = '0;
      if (clr) nxt_state = ST_OFF;
    end else if (kill_db || !enable) begin
      nxt_state = ST_OFF;
      nxt_cnt   = '0;
      nxt_idx   = '0;
      nxt_en    = '0;
    end else begin
      unique case (state)
        ST_OFF: begin
          if (!fault) begin
            nxt_state = ST_ARMING;
            nxt_cnt   = ARM_LOAD;
          end
        end
        ST_ARMING: begin
          if (cnt != '0) begin
            nxt_cnt = cnt - 1'b1;
          end else if (N_RAILS == 1) begin
            nxt_state = ST_ON;
            nxt_en    = ALL_ON;
          end else begin
            nxt_state = ST_RAMP;
            nxt_idx   = '0;
            nxt_cnt   = STG_LOAD;
            nxt_en    = N_RAILS'(1);
          end
        end
        ST_RAMP: begin
          if (cnt != '0) begin
            nxt_cnt = cnt - 1'b1;
          end else begin
            nxt_idx = idx + 3'd1;
            nxt_cnt = STG_LOAD;
            nxt_en  = motor_en | (N_RAILS'(1) << (idx + 3'd1));
            if ((idx + 3'd1) == LAST_IDX) nxt_state = ST_ON;
          end
        end
        ST_ON: nxt_en = ALL_ON;
        default: begin
          nxt_state = ST_OFF;
          nxt_en    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_OFF;
      cnt      <= '0;
      idx      <= '0;
      motor_en <= '0;
      fault    <= 1'b0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      idx      <= nxt_idx;
      motor_en <= nxt_en;
      fault    <= (nxt_state == ST_FAULT);
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      REG_CTRL: rd_mux[CTRL_ENABLE] = enable;
      REG_STATUS: begin
        rd_mux[2:0]                  = state;
        rd_mux[STAT_KILL]            = kill_db;
        rd_mux[STAT_FAULT]           = fault;
        rd_mux[STAT_MOTOR +: N_RAILS] = motor_en;
      end
      REG_KCOUNT: rd_mux[15:0] = kill_count;
      REG_RSVD:   rd_mux       = '0;
      default:    rd_mux       = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable     <= 1'b0;
      kill_count <= '0;
      readdata   <= '0;
    end else begin
      if (wr && (address == REG_CTRL)) enable <= writedata[CTRL_ENABLE];
      if (wr && (address == REG_KCOUNT))
        kill_count <= '0;
      else if (kill_rise && (kill_count != KCOUNT_MAX))
        kill_count <= kill_count + 16'd1;
      if (rd) readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_pwr_kill_sequencer.sv
// Directed + randomized bench; reference model tracks time since
// arming and a window of raw kill samples rather than FSM state.
module tb_pwr_kill_sequencer;

  localparam int N   = 4;
  localparam int DB  = 4;
  localparam int ARM = 10;
  localparam int STG = 3;

  localparam int M_OFF   = 0;
  localparam int M_RUN   = 1;
  localparam int M_FAULT = 2;

  logic         clk        = 1'b0;
  logic         reset      = 1'b0;
  logic         chipselect = 1'b0;
  logic [1:0]   address    = '0;
  logic         write      = 1'b0;
  logic         read       = 1'b0;
  logic [31:0]  writedata  = '0;
  logic [31:0]  readdata;
  logic         kill_sw    = 1'b0;
  logic         error      = 1'b0;
  logic [N-1:0] motor_en;
  logic         fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwr_kill_sequencer #(
    .N_RAILS         (N),
    .DEBOUNCE_CYCLES (DB),
    .ARM_DELAY       (ARM),
    .STAGGER         (STG)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .address    (address),
    .write      (write),
    .read       (read),
    .writedata  (writedata),
    .readdata   (readdata),
    .kill_sw    (kill_sw),
    .error      (error),
    .motor_en   (motor_en),
    .fault      (fault)
  );

  int          k;
  bit          kq[$];
  bit          eq[$];
  int          m_mode;
  int          t_arm;
  int          m_state;
  bit          m_db;
  bit          m_fault;
  bit          m_enable;
  logic [N-1:0] m_en;
  logic [15:0] m_kc;
  logic [31:0] m_rd;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    kq = {};
    eq = {};
    for (int i = 0; i < 8; i++) begin
      kq.push_back(1'b1);
      eq.push_back(1'b0);
    end
    m_mode   = M_OFF;
    t_arm    = 0;
    m_state  = 0;
    m_db     = 1'b1;
    m_fault  = 1'b0;
    m_enable = 1'b0;
    m_en     = '0;
    m_kc     = '0;
    m_rd     = '0;
  endtask

  task automatic model_step();
    int n;
    int e;
    int rails;
    bit es, wr, rdo, clr, flip, rise;
    k++;
    kq.push_back(kill_sw);
    eq.push_back(error);
    if (kq.size() > 16) begin
      void'(kq.pop_front());
      void'(eq.pop_front());
    end
    n   = kq.size();
    es  = eq[n-3];
    wr  = chipselect && write;
    rdo = chipselect && read && !wr;
    clr = wr && (address == 2'd0) && writedata[1];
    if (rdo) begin
      case (address)
        2'd0:    m_rd = {31'd0, m_enable};
        2'd1:    m_rd = {16'd0, 8'(m_en), 3'd0, m_fault, m_db, 3'(m_state)};
        2'd2:    m_rd = {16'd0, m_kc};
        default: m_rd = '0;
      endcase
    end
    if (es) m_mode = M_FAULT;
    else if (m_mode == M_FAULT) begin
      if (clr) m_mode = M_OFF;
    end else if (m_db || !m_enable) m_mode = M_OFF;
    else if (m_mode == M_OFF) begin
      m_mode = M_RUN;
      t_arm  = k;
    end
    flip = 1'b1;
    for (int i = 0; i < DB; i++)
      if (kq[n-3-i] == m_db) flip = 1'b0;
    rise = flip && !m_db;
    if (flip) m_db = !m_db;
    if (wr && (address == 2'd0)) m_enable = writedata[0];
    if (wr && (address == 2'd2)) m_kc = '0;
    else if (rise && (m_kc != 16'hFFFF)) m_kc = m_kc + 16'd1;
    m_fault = (m_mode == M_FAULT);
    m_en = '0;
    if (m_mode == M_RUN) begin
      e = k - t_arm;
      if (e < ARM) m_state = 1;
      else begin
        rails = (e - ARM) / STG + 1;
        if (rails >= N) begin
          rails   = N;
          m_state = 3;
        end else m_state = 2;
        for (int i = 0; i < rails; i++) m_en[i] = 1'b1;
      end
    end else m_state = (m_mode == M_FAULT) ? 4 : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("motor_en", motor_en, m_en);
    chk("fault", fault, m_fault);
    chk("readdata", readdata, m_rd);
  endtask

  task automatic bus(bit w, bit r, logic [1:0] a, logic [31:0] d);
    chipselect = 1'b1;
    write      = w;
    read       = r;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
  endtask

  task automatic wait_en(logic [N-1:0] tgt, int lim, string tag);
    int n = 0;
    while (motor_en !== tgt && n < lim) begin
      tick();
      n++;
    end
    chk(tag, motor_en, tgt);
  endtask

  task automatic do_reset();
    #3 reset = 1'b0;
    #1;
    chk("arst_motor", motor_en, 0);
    chk("arst_fault", fault, 0);
    chk("arst_rd", readdata, 0);
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  initial begin
    int op;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_motor", motor_en, 0);
    chk("rst_fault", fault, 0);
    chk("rst_rd", readdata, 0);
    reset = 1'b1;
    model_reset();

    // 1: debounce release, arming, staggered ramp
    bus(1, 0, 2'd0, 32'h1);
    repeat (4) tick();
    bus(0, 1, 2'd1, 0);
    chk("db_hold", readdata[3], 1);
    bus(0, 1, 2'd1, 0);
    chk("db_release", readdata[3], 0);
    bus(0, 1, 2'd1, 0);
    chk("st_arming", readdata[2:0], 1);
    wait_en(4'b0001, 30, "ramp_r0");
    repeat (3) tick();
    chk("ramp_r1", motor_en, 4'b0011);
    repeat (3) tick();
    chk("ramp_r2", motor_en, 4'b0111);
    repeat (3) tick();
    chk("ramp_r3", motor_en, 4'b1111);
    bus(0, 1, 2'd1, 0);
    chk("st_on", readdata[2:0], 3);

    // 2: glitch rejected, sustained kill, auto re-arm
    kill_sw = 1'b1;
    repeat (2) tick();
    kill_sw = 1'b0;
    repeat (6) tick();
    chk("glitch", motor_en, 4'b1111);
    kill_sw = 1'b1;
    repeat (8) tick();
    chk("kill_off", motor_en, 0);
    bus(0, 1, 2'd1, 0);
    chk("kill_status", readdata[3:0], 4'h8);
    bus(0, 1, 2'd2, 0);
    chk("kcount_1", readdata, 1);
    kill_sw = 1'b0;
    wait_en(4'b0001, 40, "rearm");

    // 3: fault in ramp, clear blocked while error high
    wait_en(4'b0011, 10, "ramp_mid");
    error = 1'b1;
    repeat (3) tick();
    chk("fault_drop", motor_en, 0);
    chk("fault_set", fault, 1);
    bus(0, 1, 2'd1, 0);
    chk("st_fault", readdata[2:0], 4);
    bus(1, 0, 2'd0, 32'h3);
    repeat (2) tick();
    chk("clr_blocked", fault, 1);
    error = 1'b0;
    repeat (3) tick();
    bus(1, 0, 2'd0, 32'h3);
    bus(0, 1, 2'd1, 0);
    chk("st_cleared", readdata[2:0], 0);
    bus(0, 1, 2'd1, 0);
    chk("st_rearm", readdata[2:0], 1);

    // 4: error and kill together, disable while arming
    error   = 1'b1;
    kill_sw = 1'b1;
    repeat (8) tick();
    bus(0, 1, 2'd1, 0);
    chk("err_over_kill", readdata[2:0], 4);
    error   = 1'b0;
    kill_sw = 1'b0;
    repeat (8) tick();
    bus(1, 0, 2'd0, 32'h3);
    tick();
    bus(1, 0, 2'd0, 32'h0);
    repeat (12) tick();
    chk("disable_off", motor_en, 0);
    bus(0, 1, 2'd1, 0);
    chk("st_disabled", readdata[2:0], 0);

    // 5: asynchronous reset mid-ramp
    bus(1, 0, 2'd0, 32'h1);
    wait_en(4'b0011, 40, "ramp_pre_rst");
    kill_sw = 1'b1;
    do_reset();
    bus(0, 1, 2'd0, 0);
    chk("r5_ctrl", readdata, 0);
    bus(0, 1, 2'd1, 0);
    chk("r5_status", readdata, 32'h8);
    bus(0, 1, 2'd2, 0);
    chk("r5_kcount", readdata, 0);
    bus(0, 1, 2'd3, 0);
    chk("r5_rsvd", readdata, 0);

    // 6: KCOUNT clear, read/write collision, reserved
    kill_sw = 1'b0;
    repeat (8) tick();
    kill_sw = 1'b1;
    repeat (8) tick();
    bus(0, 1, 2'd2, 0);
    chk("kcount_pre", readdata, 1);
    bus(1, 0, 2'd2, $urandom);
    bus(0, 1, 2'd2, 0);
    chk("kcount_clr", readdata, 0);
    bus(0, 1, 2'd1, 0);
    chk("status_pre", readdata, 32'h8);
    bus(1, 1, 2'd0, 32'h1);
    chk("rw_hold", readdata, 32'h8);
    bus(0, 1, 2'd0, 0);
    chk("rw_write", readdata, 1);
    bus(1, 0, 2'd3, 32'hFFFF_FFFF);
    bus(0, 1, 2'd3, 0);
    chk("rsvd_zero", readdata, 0);

    // randomized traffic against the model
    kill_sw = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(29) == 0) kill_sw = !kill_sw;
      if (!error && $urandom_range(199) == 0) error = 1'b1;
      else if (error && $urandom_range(9) == 0) error = 1'b0;
      op = $urandom_range(9);
      chipselect = (op < 4);
      write      = chipselect && ($urandom_range(2) == 0);
      read       = chipselect && ($urandom_range(1) == 0);
      address    = 2'($urandom_range(3));
      writedata  = $urandom;
      if (address == 2'd0) writedata[0] = ($urandom_range(9) != 0);
      if (address == 2'd2 && $urandom_range(3) != 0) write = 1'b0;
      tick();
    end
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
